// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the PPU VRAM bus arbiter.
// The palette mirror helper is used only when VRAM_ARB_PALETTE_EN is defined.
package vram_arb_pkg;

  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3} bus_state_e;

  typedef enum logic {REQ_FETCH, REQ_CPU} req_e;

  localparam logic [13:0] PAL_BASE = 14'h3F00;

  // $3F10/$14/$18/$1C alias the backdrop entries $3F00/$04/$08/$0C.
  function automatic logic [4:0] pal_index(input logic [13:0] addr);
    pal_index = addr[4:0];
    if (addr[4] && (addr[1:0] == 2'b00)) pal_index[4] = 1'b0;
  endfunction

endpackage

// File: rtl/vram_bus_cycle.sv
// Fixed 4-phase VRAM bus sequencer: PH0 address/ALE, PH1 hold (+write data),
// PH2/PH3 strobe, read data captured on the edge leaving PH3.
module vram_bus_cycle
  import vram_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] addr,
  input  logic        we,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output bus_state_e  state,
  output logic        arb_window,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_data_oe,
  input  logic [7:0]  vram_rdata,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n
);

  bus_state_e  state_q, state_d;
  logic [13:0] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        strobe;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == PH3);
      if ((state_q == PH3) && !we_q) rdata <= vram_rdata;
      if (start && arb_window) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PH0;
      PH0:     state_d = PH1;
      PH1:     state_d = PH2;
      PH2:     state_d = PH3;
      PH3:     state_d = start ? PH0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the phase register so a reset drops them at once.
  assign arb_window   = (state_q == IDLE) || (state_q == PH3);
  assign strobe       = (state_q == PH2) || (state_q == PH3);
  assign ale          = (state_q == PH0);
  assign vram_data_oe = we_q && (strobe || (state_q == PH1));
  assign rd_n         = !(strobe && !we_q);
  assign wr_n         = !(strobe && we_q);
  assign vram_addr    = addr_q;
  assign vram_wdata   = wdata_q;
  assign state        = state_q;

endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the PPU VRAM bus between the tile fetcher and the CPU $2007 port.
// Optional VRAM_ARB_PALETTE_EN serves $3Fxx CPU accesses from an internal palette RAM.
module vram_bus_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned CPU_MAX_WAIT = 8,
  parameter logic [13:0] PAL_BASE     = vram_arb_pkg::PAL_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        render_active,
  input  logic        fetch_req,
  input  logic [13:0] fetch_addr,
  output logic        fetch_grant,
  output logic        fetch_valid,
  output logic [7:0]  fetch_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_data_oe,
  input  logic [7:0]  vram_rdata,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output bus_state_e  dbg_state
);

  localparam int WW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(CPU_MAX_WAIT);
`ifdef VRAM_ARB_PALETTE_EN
  localparam bit PAL_EN = 1'b1;
`else
  localparam bit PAL_EN = 1'b0;
`endif

  logic          arb_window, bus_start, bus_done;
  logic [7:0]    bus_rdata;
  logic          grant_fetch, grant_cpu, cpu_wins, cpu_pending, cpu_busy;
  logic          pal_hit, pal_ack, pal_we;
  logic [7:0]    pal_rdata;
  logic [WW-1:0] wait_cnt;
  req_e          cur_owner, done_owner;
  logic          cur_we, done_we;
  logic          bus_cpu_ack, cpu_rd_ack;
  logic [7:0]    cpu_rd_now, fetch_data_q, cpu_rdata_q;
  logic [13:0]   sel_addr;
  logic          sel_we;

  assign pal_hit     = PAL_EN && (cpu_addr[13:8] == PAL_BASE[13:8]);
  // cpu_busy masks the still-high cpu_req while its own access is in flight.
  assign cpu_pending = cpu_req && !cpu_busy && !pal_hit;
  assign cpu_wins    = cpu_pending && (CPU_MAX_WAIT != 0) && (wait_cnt == MAX_W);

  always_comb begin
    grant_fetch = 1'b0;
    grant_cpu   = 1'b0;
    if (arb_window) begin
      if (render_active) begin
        if (cpu_wins)         grant_cpu   = 1'b1;
        else if (fetch_req)   grant_fetch = 1'b1;
        else if (cpu_pending) grant_cpu   = 1'b1;
      end else begin
        if (cpu_pending)      grant_cpu   = 1'b1;
        else if (fetch_req)   grant_fetch = 1'b1;
      end
    end
  end

  assign bus_start = grant_fetch || grant_cpu;
  assign sel_addr  = grant_cpu ? cpu_addr : fetch_addr;
  assign sel_we    = grant_cpu && cpu_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_grant  <= 1'b0;
      wait_cnt     <= '0;
      cpu_busy     <= 1'b0;
      cur_owner    <= REQ_FETCH;
      cur_we       <= 1'b0;
      done_owner   <= REQ_FETCH;
      done_we      <= 1'b0;
      fetch_data_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      fetch_grant <= grant_fetch;
      if (grant_cpu || !cpu_req)                  wait_cnt <= '0;
      else if (grant_fetch && (wait_cnt != MAX_W)) wait_cnt <= wait_cnt + 1'b1;
      if (grant_cpu)        cpu_busy <= 1'b1;
      else if (bus_cpu_ack) cpu_busy <= 1'b0;
      if (bus_start) begin
        cur_owner <= grant_cpu ? REQ_CPU : REQ_FETCH;
        cur_we    <= sel_we;
      end
      // The next access may be granted on the PH3 edge, so remember who finishes.
      if (dbg_state == PH3) begin
        done_owner <= cur_owner;
        done_we    <= cur_we;
      end
      if (fetch_valid) fetch_data_q <= bus_rdata;
      if (cpu_rd_ack)  cpu_rdata_q  <= cpu_rd_now;
    end
  end

`ifdef VRAM_ARB_PALETTE_EN
  logic [5:0] pal_ram [32];
  logic       pal_go;

  assign pal_go = cpu_req && pal_hit && !pal_ack && !cpu_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      pal_ack   <= 1'b0;
      pal_we    <= 1'b0;
      pal_rdata <= '0;
    end else begin
      pal_ack <= pal_go;
      if (pal_go) begin
        pal_we <= cpu_we;
        if (cpu_we) pal_ram[pal_index(cpu_addr)] <= cpu_wdata[5:0];
        else        pal_rdata <= {2'b00, pal_ram[pal_index(cpu_addr)]};
      end
    end
  end
`else
  assign pal_ack   = 1'b0;
  assign pal_we    = 1'b0;
  assign pal_rdata = 8'h00;
`endif

  assign fetch_valid = bus_done && (done_owner == REQ_FETCH);
  assign bus_cpu_ack = bus_done && (done_owner == REQ_CPU);
  assign cpu_ack     = bus_cpu_ack || pal_ack;
  assign cpu_rd_ack  = (bus_cpu_ack && !done_we) || (pal_ack && !pal_we);
  assign cpu_rd_now  = pal_ack ? pal_rdata : bus_rdata;
  assign fetch_data  = fetch_valid ? bus_rdata : fetch_data_q;
  assign cpu_rdata   = cpu_rd_ack ? cpu_rd_now : cpu_rdata_q;

  vram_bus_cycle u_cycle (
    .clock        (clock),
    .reset        (reset),
    .start        (bus_start),
    .addr         (sel_addr),
    .we           (sel_we),
    .wdata        (cpu_wdata),
    .done         (bus_done),
    .rdata        (bus_rdata),
    .state        (dbg_state),
    .arb_window   (arb_window),
    .vram_addr    (vram_addr),
    .vram_wdata   (vram_wdata),
    .vram_data_oe (vram_data_oe),
    .vram_rdata   (vram_rdata),
    .ale          (ale),
    .rd_n         (rd_n),
    .wr_n         (wr_n)
  );

endmodule

// File: doc/vram_bus_arbiter.md
Name: vram_bus_arbiter

Overview:
Owns the PPU's single VRAM bus and shares it between two requesters: the background tile fetch path and the CPU PPUDATA ($2007) port. Runs every VRAM access as a fixed 4-phase bus cycle (address/ALE, hold, strobe, capture). Gives the fetch path priority while rendering, with a bounded-starvation slot for the CPU. Sits between the PPU core and the external VRAM/CHR memory and address latch.

Parameters:
CPU_MAX_WAIT, 8, consecutive fetch grants allowed while cpu_req is pending before the CPU is forced a slot; 0 = CPU never preempts while render_active
PAL_BASE, 14'h3F00, base of the palette window (used only with the optional feature)

Ports:
clock  in  1  PPU master clock; all logic on posedge
reset  in  1  synchronous, active-high
render_active  in  1  rendering enabled and in visible/pre-render fetch window
fetch_req  in  1  level; fetcher wants an access
fetch_addr  in  14  fetch address, sampled at grant
fetch_grant  out  1  1-cycle pulse: fetch_addr sampled
fetch_valid  out  1  1-cycle pulse: fetch_data valid
fetch_data  out  8  read data, held until next fetch_valid
cpu_req  in  1  level; held until cpu_ack
cpu_we  in  1  1 = write
cpu_addr  in  14  sampled at grant
cpu_wdata  in  8  sampled at grant
cpu_ack  out  1  1-cycle pulse: access complete
cpu_rdata  out  8  read data, held until next CPU read ack
vram_addr  out  14  bus address
vram_wdata  out  8  bus write data
vram_data_oe  out  1  drive vram_wdata onto bus
vram_rdata  in  8  bus read data
ale  out  1  address latch enable, active high
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low

Behaviour:
- Reset: state IDLE; ale=0, rd_n=1, wr_n=1, vram_data_oe=0, vram_addr=0, vram_wdata=0; fetch_grant, fetch_valid, cpu_ack = 0; fetch_data, cpu_rdata = 0; wait counter 0.
- Reset mid-cycle: abort; strobes deassert at that edge; no ack or valid issued for the aborted access.
- States: IDLE -> PH0 -> PH1 -> PH2 -> PH3 -> (PH0 if a request is pending, else IDLE).
- Arbitration happens in IDLE and PH3 only. The winner's address/data/we are registered on that edge and its grant pulses (fetch_grant, or an internal grant for the CPU) in the following PH0 cycle.
- Priority when render_active=1: fetch wins, unless cpu_req is pending, wait counter == CPU_MAX_WAIT, and CPU_MAX_WAIT != 0; then the CPU wins.
- Priority when render_active=0: the CPU wins; fetch is served only when cpu_req=0.
- Wait counter: increments on each fetch grant while cpu_req=1; clears on CPU grant or when cpu_req=0; saturates at CPU_MAX_WAIT.
- PH0: vram_addr = latched address, ale=1.
- PH1: ale=0, address held. On a write, vram_data_oe=1 and vram_wdata driven.
- PH2 and PH3: rd_n=0 for a read, or wr_n=0 for a write.
- Read capture: vram_rdata is captured on the edge leaving PH3.
- Completion: fetch_valid or cpu_ack pulses in the cycle after PH3 (this overlaps the next PH0). Strobes and oe deassert on that same edge.
- Throughput: one access per 4 clocks back-to-back. Latency from request seen in IDLE to valid/ack is 5 clocks.
- Simultaneous requests: resolved only by the priority rules above; the loser stays pending with no state lost.
- cpu_req must drop the cycle after cpu_ack, otherwise it is a new request.
- fetch_req deasserted before grant: no access.

Optional Feature:
VRAM_ARB_PALETTE_EN
- Defined: CPU accesses with cpu_addr[13:8]==6'h3F are served from an internal 32x6-bit palette RAM, with no bus cycle.
  - Address index = addr[4:0]; $3F10/$14/$18/$1C mirror $3F00/$04/$08/$0C.
  - cpu_ack pulses 1 clock after the request is seen; the ack is allowed even while a bus cycle is in flight.
  - Read data = {2'b00, entry}.
- Undefined: these accesses go to the bus like any other address.

Decomposition:
- Package vram_arb_pkg holds: state enum (IDLE, PH0-PH3), requester enum (REQ_FETCH, REQ_CPU), PAL_BASE, palette mirror function.
- Sub-module vram_bus_cycle: the 4-phase sequencer, taking start/addr/we/wdata and returning done/rdata. The arbiter and wait counter stay in the top module.

Test Plan:
- Reset, then idle 10 clocks -> ale=0, rd_n=1, wr_n=1, oe=0, no pulses.
- render_active=0, CPU write $2005<=8'hA5 -> ale high 1 cycle with vram_addr=14'h2005; oe=1 from PH1; wr_n low exactly 2 cycles; cpu_ack 5 clocks after request.
- render_active=1, fetch_req held, CHR returns 8'h3C at $1008 -> fetch_valid every 4 clocks, fetch_data=8'h3C.
- CPU_MAX_WAIT=2, render_active=1, fetch and CPU read $23C0 both pending -> grant order F,F,C,F,F; cpu_rdata = memory value.
- Assert reset during PH2 of a read -> rd_n=1 next cycle, no fetch_valid, state IDLE.
- With VRAM_ARB_PALETTE_EN: write $3F10<=6'h2A, then read $3F00 -> rdata 8'h2A, ale never asserted, ack 1 clock after each request.
